// File: rtl/hub75_pkg.sv
// hub75_pkg: shared geometry, colour lane indices and pixel type for the
// HUB75 panel-side receiver.
package hub75_pkg;

  localparam int unsigned COLS    = 32;
  localparam int unsigned ROWS    = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned NCOLOUR = 6;

  // Serial colour lane indices (upper half R1G1B1, lower half R2G2B2)
  localparam int unsigned C_R1 = 0;
  localparam int unsigned C_G1 = 1;
  localparam int unsigned C_B1 = 2;
  localparam int unsigned C_R2 = 3;
  localparam int unsigned C_G2 = 4;
  localparam int unsigned C_B2 = 5;

  // Colour plane indices inside one capture-buffer row
  localparam int unsigned PL_R = 0;
  localparam int unsigned PL_G = 1;
  localparam int unsigned PL_B = 2;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb3_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge: two-flop synchronizer for one asynchronous pin, plus a
// third register for rising-edge detection.
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous pin
//   rise_c   : one-cycle pulse when the synchronized level goes 0 -> 1
module hub75_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_c
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Synchronizer chain plus edge-history register
  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-side receiver. Samples the driver's LED_* pins,
// rebuilds each scanned row from the serial RGB stream, commits it on latch
// into a 2 x ROWS x COLS RGB capture buffer and measures per-row OE on-time.
//   CLK, RST             : system clock, synchronous active-high reset
//   LED_CLK/LAT/OE       : panel shift clock, latch, active-low enable (async)
//   LED_A/B/C            : row address, C = MSB
//   LED_R1..LED_B2       : serial colour data, upper/lower half
//   rd_half/rd_row/rd_col: capture-buffer read address
//   rd_rgb               : {R,G,B} at the read address, 1-cycle latency
//   row_valid, row_addr  : row commit pulse and committed row address
//   oe_cycles            : cycles OE was low during the committed row
//   err_len              : latch seen with a bit count other than COLS
//   frame_done, frame_cnt: last-row commit pulse and wrapping frame count
module hub75_rx #(
  parameter int unsigned COLS  = hub75_pkg::COLS,
  parameter int unsigned ROWS  = hub75_pkg::ROWS,
  parameter int unsigned CNT_W = hub75_pkg::CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LED_CLK,
  input  logic             LED_LAT,
  input  logic             LED_OE,
  input  logic             LED_A,
  input  logic             LED_B,
  input  logic             LED_C,
  input  logic             LED_R1,
  input  logic             LED_G1,
  input  logic             LED_B1,
  input  logic             LED_R2,
  input  logic             LED_G2,
  input  logic             LED_B2,
  input  logic             rd_half,
  input  logic [2:0]       rd_row,
  input  logic [4:0]       rd_col,
  output logic [2:0]       rd_rgb,
  output logic             row_valid,
  output logic [2:0]       row_addr,
  output logic [CNT_W-1:0] oe_cycles,
  output logic             err_len,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  import hub75_pkg::*;

  localparam int unsigned BCNT_W = $clog2(COLS) + 1;
  localparam int unsigned NPLAIN = 10;
  // OE idles high (panel dark), every other plain pin idles low
  localparam logic [NPLAIN-1:0] PLAIN_RST = {1'b1, 9'b0};

  // ---------------------------------------------------------------- sync
  logic clk_rise_c;
  logic lat_rise_c;

  hub75_sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
    .clk    (CLK),
    .rst    (RST),
    .d_i    (LED_CLK),
    .rise_c (clk_rise_c)
  );

  hub75_sync_edge #(.RST_VAL(1'b0)) u_sync_lat (
    .clk    (CLK),
    .rst    (RST),
    .d_i    (LED_LAT),
    .rise_c (lat_rise_c)
  );

  logic [NPLAIN-1:0] pin_raw;
  logic [NPLAIN-1:0] pin_s1_q, pin_s1_d;
  logic [NPLAIN-1:0] pin_s2_q, pin_s2_d;

  // Lane order matches the C_* indices so dat_s[C_xx] is that colour
  assign pin_raw = {LED_OE, LED_C, LED_B, LED_A,
                    LED_B2, LED_G2, LED_R2, LED_B1, LED_G1, LED_R1};

  logic [NCOLOUR-1:0] dat_s;
  logic [2:0]         addr_s;
  logic               oe_s;

  assign dat_s  = pin_s2_q[NCOLOUR-1:0];
  assign addr_s = pin_s2_q[8:6];
  assign oe_s   = pin_s2_q[9];

  // ---------------------------------------------------------------- state
  logic [COLS-1:0]   sr_q  [NCOLOUR];
  logic [COLS-1:0]   sr_d  [NCOLOUR];
  logic [COLS-1:0]   mem_q [2][ROWS][3];
  logic [COLS-1:0]   mem_d [2][ROWS][3];
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  oecnt_q, oecnt_d;
  logic              armed_q, armed_d;
  rgb3_t             rd_rgb_q, rd_rgb_d;
  logic              row_valid_q, row_valid_d;
  logic [2:0]        row_addr_q, row_addr_d;
  logic [CNT_W-1:0]  oe_cycles_q, oe_cycles_d;
  logic              err_len_q, err_len_d;
  logic              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  // Shift, commit, counters and readout
  always_comb begin
    pin_s1_d     = pin_raw;
    pin_s2_d     = pin_s1_q;
    sr_d         = sr_q;
    mem_d        = mem_q;
    bcnt_d       = bcnt_q;
    oecnt_d      = oecnt_q;
    armed_d      = armed_q;
    row_valid_d  = 1'b0;
    row_addr_d   = row_addr_q;
    oe_cycles_d  = oe_cycles_q;
    err_len_d    = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    // Reads the pre-commit buffer, so a same-cycle write is not visible
    rd_rgb_d.r = mem_q[rd_half][rd_row][PL_R][rd_col];
    rd_rgb_d.g = mem_q[rd_half][rd_row][PL_G][rd_col];
    rd_rgb_d.b = mem_q[rd_half][rd_row][PL_B][rd_col];

    if (!oe_s && (oecnt_q != {CNT_W{1'b1}})) begin
      oecnt_d = oecnt_q + CNT_W'(1);
    end

    // New bit enters at the MSB so the first column ends up at bit 0
    if (clk_rise_c) begin
      for (int c = 0; c < NCOLOUR; c++) begin
        sr_d[c] = {dat_s[c], sr_q[c][COLS-1:1]};
      end
      if (bcnt_q != {BCNT_W{1'b1}}) begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end

    // Commit sees post-shift data: the driver raises LAT with the last clock
    if (lat_rise_c) begin
      if (armed_q) begin
        if (bcnt_d == BCNT_W'(COLS)) begin
          mem_d[0][addr_s][PL_R] = sr_d[C_R1];
          mem_d[0][addr_s][PL_G] = sr_d[C_G1];
          mem_d[0][addr_s][PL_B] = sr_d[C_B1];
          mem_d[1][addr_s][PL_R] = sr_d[C_R2];
          mem_d[1][addr_s][PL_G] = sr_d[C_G2];
          mem_d[1][addr_s][PL_B] = sr_d[C_B2];
          row_valid_d = 1'b1;
          row_addr_d  = addr_s;
          oe_cycles_d = oecnt_q;
          if (addr_s == 3'(ROWS - 1)) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          end
        end else begin
          err_len_d = 1'b1;
        end
      end
      // First latch after reset only resynchronizes to a row boundary
      armed_d = 1'b1;
      bcnt_d  = '0;
      oecnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pin_s1_q <= PLAIN_RST;
      pin_s2_q <= PLAIN_RST;
      for (int c = 0; c < NCOLOUR; c++) begin
        sr_q[c] <= '0;
      end
      for (int h = 0; h < 2; h++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int p = 0; p < 3; p++) begin
            mem_q[h][r][p] <= '0;
          end
        end
      end
      bcnt_q       <= '0;
      oecnt_q      <= '0;
      armed_q      <= 1'b0;
      rd_rgb_q     <= '0;
      row_valid_q  <= 1'b0;
      row_addr_q   <= '0;
      oe_cycles_q  <= '0;
      err_len_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      pin_s1_q     <= pin_s1_d;
      pin_s2_q     <= pin_s2_d;
      sr_q         <= sr_d;
      mem_q        <= mem_d;
      bcnt_q       <= bcnt_d;
      oecnt_q      <= oecnt_d;
      armed_q      <= armed_d;
      rd_rgb_q     <= rd_rgb_d;
      row_valid_q  <= row_valid_d;
      row_addr_q   <= row_addr_d;
      oe_cycles_q  <= oe_cycles_d;
      err_len_q    <= err_len_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign rd_rgb     = rd_rgb_q;
  assign row_valid  = row_valid_q;
  assign row_addr   = row_addr_q;
  assign oe_cycles  = oe_cycles_q;
  assign err_len    = err_len_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: drives HUB75 pin waveforms with random row images and checks
// the receiver against a pixel-image reference model.
`timescale 1ns/1ps
module tb_hub75_rx;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic LED_CLK = 1'b0, LED_LAT = 1'b0, LED_OE = 1'b1;
  logic LED_A = 1'b0, LED_B = 1'b0, LED_C = 1'b0;
  logic LED_R1 = 1'b0, LED_G1 = 1'b0, LED_B1 = 1'b0;
  logic LED_R2 = 1'b0, LED_G2 = 1'b0, LED_B2 = 1'b0;
  logic       rd_half = 1'b0;
  logic [2:0] rd_row = 3'd0;
  logic [4:0] rd_col = 5'd0;
  logic [2:0]  rd_rgb;
  logic        row_valid;
  logic [2:0]  row_addr;
  logic [15:0] oe_cycles;
  logic        err_len;
  logic        frame_done;
  logic [15:0] frame_cnt;

  always #5 CLK = ~CLK;

  hub75_rx #(.COLS(32), .ROWS(8), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LED_CLK    (LED_CLK),
    .LED_LAT    (LED_LAT),
    .LED_OE     (LED_OE),
    .LED_A      (LED_A),
    .LED_B      (LED_B),
    .LED_C      (LED_C),
    .LED_R1     (LED_R1),
    .LED_G1     (LED_G1),
    .LED_B1     (LED_B1),
    .LED_R2     (LED_R2),
    .LED_G2     (LED_G2),
    .LED_B2     (LED_B2),
    .rd_half    (rd_half),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_rgb     (rd_rgb),
    .row_valid  (row_valid),
    .row_addr   (row_addr),
    .oe_cycles  (oe_cycles),
    .err_len    (err_len),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Observed pulses, sampled on the falling edge
  int          rv_n = 0, err_n = 0, fd_n = 0;
  logic [2:0]  last_addr = 3'd0;
  logic [15:0] last_oe = 16'd0;
  logic [2:0]  fd_addr = 3'd0;

  always @(negedge CLK) begin
    if (row_valid) begin
      rv_n++;
      last_addr = row_addr;
      last_oe   = oe_cycles;
    end
    if (err_len) err_n++;
    if (frame_done) begin
      fd_n++;
      fd_addr = row_addr;
    end
  end

  // Reference model: panel image plus expected event counts
  logic [2:0]  img [2][8][32];
  bit          armed_m = 1'b0;
  int          exp_rv = 0, exp_err = 0, exp_fd = 0, frames_m = 0, exp_oe = 0;
  logic [2:0]  exp_addr = 3'd0;
  logic [31:0] row_d [6];

  task automatic hold(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clear_model();
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 32; c++) img[h][r][c] = 3'b000;
    armed_m  = 1'b0;
    frames_m = 0;
  endtask

  // A latch after exactly 32 clocks stores the row; column i is the i-th bit sent
  task automatic apply_model(input logic [2:0] addr, input int n, input int oe_n);
    if (armed_m) begin
      if (n == 32) begin
        for (int c = 0; c < 32; c++) begin
          img[0][addr][c] = {row_d[0][c], row_d[1][c], row_d[2][c]};
          img[1][addr][c] = {row_d[3][c], row_d[4][c], row_d[5][c]};
        end
        exp_rv++;
        exp_addr = addr;
        exp_oe   = oe_n;
        if (addr == 3'd7) begin
          exp_fd++;
          frames_m++;
        end
      end else begin
        exp_err++;
      end
    end
    armed_m = 1'b1;
  endtask

  task automatic rand_row();
    for (int c = 0; c < 6; c++) row_d[c] = $urandom();
  endtask

  // Data changes with the LED_CLK fall; optional LAT rise with this clock rise
  task automatic shift_bit(input int i, input bit lat);
    LED_CLK = 1'b0;
    {LED_R1, LED_G1, LED_B1, LED_R2, LED_G2, LED_B2} =
      {row_d[0][i % 32], row_d[1][i % 32], row_d[2][i % 32],
       row_d[3][i % 32], row_d[4][i % 32], row_d[5][i % 32]};
    hold(4);
    LED_CLK = 1'b1;
    if (lat) LED_LAT = 1'b1;
    hold(4);
  endtask

  task automatic send_row(input logic [2:0] addr, input int n, input bit coinc, input int oe_n);
    {LED_C, LED_B, LED_A} = addr;
    for (int i = 0; i < n; i++) shift_bit(i, coinc && (i == n - 1));
    if (!coinc) begin
      LED_CLK = 1'b0;
      hold(4);
      if (oe_n > 0) begin
        LED_OE = 1'b0;
        hold(oe_n);
        LED_OE = 1'b1;
        hold(4);
      end
      LED_LAT = 1'b1;
      hold(4);
    end
    LED_LAT = 1'b0;
    LED_CLK = 1'b0;
    hold(6);
    apply_model(addr, n, oe_n);
  endtask

  task automatic rd(input logic h, input logic [2:0] r, input logic [4:0] c, output logic [2:0] v);
    @(negedge CLK);
    rd_half = h;
    rd_row  = r;
    rd_col  = c;
    @(negedge CLK);
    v = rd_rgb;
  endtask

  task automatic check_row(input string tag, input int r);
    logic [2:0] v;
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < 32; c++) begin
        rd(1'(h), 3'(r), 5'(c), v);
        checks++;
        assert (v === img[h][r][c]) else begin
          errors++;
          $error("FAIL %s[%0d][%0d][%0d]: got %b expected %b", tag, h, r, c, v, img[h][r][c]);
        end
      end
  endtask

  task automatic check_buf(input string tag);
    for (int r = 0; r < 8; r++) check_row(tag, r);
  endtask

  task automatic check_out_zero(input string pfx);
    check({pfx, "_rd_rgb"},     32'(rd_rgb),     0);
    check({pfx, "_row_valid"},  32'(row_valid),  0);
    check({pfx, "_row_addr"},   32'(row_addr),   0);
    check({pfx, "_oe_cycles"},  32'(oe_cycles),  0);
    check({pfx, "_err_len"},    32'(err_len),    0);
    check({pfx, "_frame_done"}, 32'(frame_done), 0);
    check({pfx, "_frame_cnt"},  32'(frame_cnt),  0);
  endtask

  initial begin
    logic [2:0] v;
    clear_model();
    for (int c = 0; c < 6; c++) row_d[c] = 32'h0;

    // Reset state
    hold(4);
    check_out_zero("rst");
    RST = 1'b0;
    hold(2);

    // First latch after reset with 5 stray clocks only arms
    rand_row();
    send_row(3'd0, 5, 1'b0, 0);
    check("arm_err", 32'(err_n), 0);
    check("arm_rv",  32'(rv_n),  0);

    // Single red pixel in column 0 of upper row 3
    for (int c = 0; c < 6; c++) row_d[c] = 32'h0;
    row_d[0] = 32'h1;
    send_row(3'd3, 32, 1'b0, 0);
    check("px_rv",   32'(rv_n), 1);
    check("px_addr", 32'(last_addr), 3);
    rd(1'b0, 3'd3, 5'd0, v);
    check("px_c0", 32'(v), 32'b100);
    rd(1'b0, 3'd3, 5'd1, v);
    check("px_c1", 32'(v), 0);
    rd(1'b1, 3'd3, 5'd0, v);
    check("px_lower", 32'(v), 0);

    // Full random frame, LAT coincident with the 32nd clock rise
    for (int r = 0; r < 8; r++) begin
      rand_row();
      send_row(3'(r), 32, 1'b1, 0);
    end
    check("frm_rv",      32'(rv_n), 32'(exp_rv));
    check("frm_fd",      32'(fd_n), 32'(exp_fd));
    check("frm_fd_addr", 32'(fd_addr), 7);
    check("frm_cnt",     32'(frame_cnt), 32'(frames_m));
    check("frm_cnt_one", 32'(frame_cnt), 1);
    check_buf("frame");

    // Short and long rows flag a length error and leave the row untouched
    rand_row();
    send_row(3'd4, 31, 1'b0, 0);
    check("short_err", 32'(err_n), 32'(exp_err));
    check("short_rv",  32'(rv_n),  32'(exp_rv));
    check_row("short_row", 4);
    rand_row();
    send_row(3'd4, 40, 1'b0, 0);
    check("long_err", 32'(err_n), 32'(exp_err));
    check("long_rv",  32'(rv_n),  32'(exp_rv));
    check_row("long_row", 4);

    // OE on-time measurement, restarting from zero each row
    rand_row();
    send_row(3'd1, 32, 1'b0, 200);
    check("oe_rv",   32'(rv_n), 32'(exp_rv));
    check("oe_200",  32'(last_oe), 200);
    check("oe_addr", 32'(last_addr), 32'(exp_addr));
    rand_row();
    send_row(3'd2, 32, 1'b1, 0);
    check("oe_zero", 32'(last_oe), 32'(exp_oe));
    rand_row();
    send_row(3'd6, 32, 1'b0, 7);
    check("oe_7",    32'(last_oe), 32'(exp_oe));
    check("oe_addr6", 32'(last_addr), 6);
    check_buf("oe_rows");

    // Reset in the middle of a row (after 17 bits)
    rand_row();
    {LED_C, LED_B, LED_A} = 3'd5;
    for (int i = 0; i < 17; i++) shift_bit(i, 1'b0);
    LED_CLK = 1'b0;
    hold(4);
    RST = 1'b1;
    hold(3);
    check_out_zero("mid_rst");
    RST = 1'b0;
    clear_model();
    hold(2);
    check_out_zero("post_rst");
    check_buf("rst_buf");

    // First full row after reset only re-arms; the next one commits
    rand_row();
    send_row(3'd2, 32, 1'b1, 0);
    check("rearm_rv",  32'(rv_n),  32'(exp_rv));
    check("rearm_err", 32'(err_n), 32'(exp_err));
    rand_row();
    send_row(3'd2, 32, 1'b0, 0);
    check("re_rv",   32'(rv_n), 32'(exp_rv));
    check("re_addr", 32'(last_addr), 2);
    check("re_fcnt", 32'(frame_cnt), 32'(frames_m));
    check_buf("rearm_buf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
